hex_display_arbiter: RTL and testbench

Shares the board's four seven-segment displays (HEX3..HEX0) between two 16-bit requesters, the CPU output port and the debug monitor. Accepts values over a valid/ready handshake with round-robin arbitration. Each accepted value is held on the displays for a minimum time before another requester may replace it. Sits between the CPU top level and the board pins, and drives active-low segment outputs directly.

---
 rtl/hex_disp_pkg.sv | 9 +
 rtl/hex_seg_decoder.sv | 10 +
 rtl/hex_display_arbiter.sv | 78 +++++++
 tb/tb_hex_display_arbiter.sv | 130 +++++++++++++
 4 files changed

// File: rtl/hex_disp_pkg.sv
// hex_disp_pkg: shared segment constants and display FSM states
package hex_disp_pkg;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    typedef enum logic [1:0] {BLANK, HOLD, OPEN} state_t;
endpackage

// File: rtl/hex_seg_decoder.sv
// hex_seg_decoder: hex nibble to active-low {g,f,e,d,c,b,a} with forced blank
module hex_seg_decoder
    import hex_disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);
    always_comb seg = blank ? SEG_BLANK : SEG_LUT[nibble];
endmodule

// File: rtl/hex_display_arbiter.sv
// hex_display_arbiter: round-robin sharing of four seven-segment displays with a minimum hold
module hex_display_arbiter
    import hex_disp_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter bit LZB         = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    input  logic [15:0] req_data0,
    input  logic [15:0] req_data1,
    output logic [1:0]  req_ready,
    output logic        owner,
    output logic        busy,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3
);
    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(HOLD_CYCLES - 1);
    state_t        state_q, state_d;
    logic [15:0]   data_q, data_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          win, xfer;
    logic [3:0]    blank;
    logic [6:0]    seg [4];
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BLANK;
            data_q  <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end
    // on a tie the requester not granted last wins
    always_comb begin
        win       = &req_valid ? !last_q : req_valid[1];
        req_ready = (rst || state_q == HOLD || req_valid == 2'b00) ? 2'b00 : (win ? 2'b10 : 2'b01);
        xfer      = |(req_valid & req_ready);
        data_d    = xfer ? (win ? req_data1 : req_data0) : data_q;
        owner_d   = xfer ? win : owner_q;
        last_d    = xfer ? win : last_q;
        cnt_d     = xfer ? CNT_INIT : (cnt_q != '0 ? cnt_q - CW'(1) : cnt_q);
    end
    always_comb begin
        state_d = xfer ? HOLD : (state_q == HOLD && cnt_q == '0) ? OPEN : state_q;
    end
    always_comb begin
        busy     = state_q == HOLD;
        blank[0] = state_q == BLANK;
        blank[1] = blank[0] || (LZB && data_q[15:4] == '0);
        blank[2] = blank[0] || (LZB && data_q[15:8] == '0);
        blank[3] = blank[0] || (LZB && data_q[15:12] == '0);
    end
    for (genvar k = 0; k < 4; k++) begin : g_dig
        hex_seg_decoder u_dec (
            .nibble (data_q[4*k +: 4]),
            .blank  (blank[k]),
            .seg    (seg[k])
        );
    end
    assign owner = owner_q;
    assign HEX0  = seg[0];
    assign HEX1  = seg[1];
    assign HEX2  = seg[2];
    assign HEX3  = seg[3];
endmodule

// File: tb/tb_hex_display_arbiter.sv
// tb_hex_display_arbiter: directed and random stimulus checked against a behavioural display model
module tb_hex_display_arbiter;
    localparam int HOLD = 4;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] d0, d1;
    logic [1:0]  a_ready, b_ready;
    logic        a_owner, b_owner, a_busy, b_busy;
    logic [6:0]  a_h0, a_h1, a_h2, a_h3, b_h0, b_h1, b_h2, b_h3;
    int checks = 0;
    int errors = 0;
    logic [6:0] lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    bit          shown;
    logic [15:0] mdata;
    bit          mowner, mlast;
    int          hrem;

    hex_display_arbiter #(.HOLD_CYCLES(HOLD), .LZB(1'b1)) u_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data0(d0), .req_data1(d1),
        .req_ready(a_ready), .owner(a_owner), .busy(a_busy),
        .HEX0(a_h0), .HEX1(a_h1), .HEX2(a_h2), .HEX3(a_h3));
    hex_display_arbiter #(.HOLD_CYCLES(HOLD), .LZB(1'b0)) u_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data0(d0), .req_data1(d1),
        .req_ready(b_ready), .owner(b_owner), .busy(b_busy),
        .HEX0(b_h0), .HEX1(b_h1), .HEX2(b_h2), .HEX3(b_h3));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] hx(input int k, input bit lzb);
        logic [15:0] s;
        s = mdata >> (4 * k);
        if (!shown) return 7'h7F;
        if (lzb && k > 0 && s == 16'd0) return 7'h7F;
        return lut[s[3:0]];
    endfunction

    function automatic logic [1:0] mready();
        if (rst || hrem > 0) return 2'b00;
        if (req_valid == 2'b11) return mlast ? 2'b01 : 2'b10;
        return req_valid;
    endfunction

    task automatic step(input logic r, input logic [1:0] v, input logic [15:0] x0, input logic [15:0] x1);
        logic [1:0] er;
        rst = r; req_valid = v; d0 = x0; d1 = x1;
        #1;
        er = mready();
        chk("ready_a", 32'(a_ready), 32'(er));
        chk("ready_b", 32'(b_ready), 32'(er));
        chk("busy_a", 32'(a_busy), 32'(hrem > 0));
        chk("busy_b", 32'(b_busy), 32'(hrem > 0));
        chk("owner_a", 32'(a_owner), 32'(mowner));
        chk("owner_b", 32'(b_owner), 32'(mowner));
        chk("hex_a", 32'({a_h3, a_h2, a_h1, a_h0}), 32'({hx(3, 1), hx(2, 1), hx(1, 1), hx(0, 1)}));
        chk("hex_b", 32'({b_h3, b_h2, b_h1, b_h0}), 32'({hx(3, 0), hx(2, 0), hx(1, 0), hx(0, 0)}));
        @(posedge clk);
        if (r) begin
            shown = 0; mdata = 16'd0; mowner = 0; mlast = 1; hrem = 0;
        end else if (er != 2'b00) begin
            shown = 1; mdata = er[1] ? x1 : x0; mowner = er[1]; mlast = er[1]; hrem = HOLD;
        end else if (hrem > 0) begin
            hrem--;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] r0, r1;
        rst = 1'b1; req_valid = 2'b00; d0 = '0; d1 = '0;
        shown = 0; mdata = 16'd0; mowner = 0; mlast = 1; hrem = 0;
        @(negedge clk);
        step(1, 2'b00, 16'h0, 16'h0);
        step(1, 2'b11, 16'h1, 16'h2);
        step(0, 2'b00, 16'h0, 16'h0);
        step(0, 2'b00, 16'h0, 16'h0);
        step(0, 2'b01, 16'h00A7, 16'h0);
        chk("a7_hex", 32'({a_h3, a_h2, a_h1, a_h0}), 32'({7'h7F, 7'h7F, 7'h08, 7'h78}));
        for (int i = 0; i < 5; i++) step(0, 2'b00, 16'h0, 16'h0);
        step(1, 2'b00, 16'h0, 16'h0);
        step(0, 2'b11, 16'h1234, 16'hBEEF);
        chk("tie_first_hex", 32'({a_h3, a_h2, a_h1, a_h0}), 32'({7'h79, 7'h24, 7'h30, 7'h19}));
        chk("tie_first_owner", 32'(a_owner), 32'd0);
        for (int i = 0; i < 4; i++) step(0, 2'b11, 16'h1234, 16'hBEEF);
        chk("tie_wait_owner", 32'(a_owner), 32'd0);
        step(0, 2'b11, 16'h1234, 16'hBEEF);
        chk("beef_hex", 32'({a_h3, a_h2, a_h1, a_h0}), 32'({7'h03, 7'h06, 7'h06, 7'h0E}));
        chk("beef_owner", 32'(a_owner), 32'd1);
        for (int i = 0; i < 5; i++) step(0, 2'b00, 16'h0, 16'h0);
        step(0, 2'b01, 16'h0000, 16'h0);
        chk("zero_lzb1", 32'({a_h3, a_h2, a_h1, a_h0}), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));
        chk("zero_lzb0", 32'({b_h3, b_h2, b_h1, b_h0}), 32'({7'h40, 7'h40, 7'h40, 7'h40}));
        for (int i = 0; i < 5; i++) step(0, 2'b00, 16'h0, 16'h0);
        step(0, 2'b01, 16'h5555, 16'h0);
        for (int i = 0; i < 6; i++) step(0, 2'b10, 16'h0, 16'h9999);
        chk("late_owner", 32'(a_owner), 32'd1);
        for (int i = 0; i < 5; i++) step(0, 2'b00, 16'h0, 16'h0);
        step(0, 2'b01, 16'h1111, 16'h0);
        step(0, 2'b10, 16'h0, 16'h8888);
        step(0, 2'b10, 16'h0, 16'h8888);
        for (int i = 0; i < 4; i++) step(0, 2'b00, 16'h0, 16'h0);
        chk("drop_hex", 32'({a_h3, a_h2, a_h1, a_h0}), 32'({7'h79, 7'h79, 7'h79, 7'h79}));
        step(0, 2'b01, 16'h7777, 16'h0);
        step(0, 2'b00, 16'h0, 16'h0);
        step(0, 2'b00, 16'h0, 16'h0);
        step(1, 2'b11, 16'h2222, 16'h3333);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_hex", 32'({a_h3, a_h2, a_h1, a_h0}), 32'h0FFF_FFFF);
        chk("rst_owner", 32'(a_owner), 32'd0);
        step(0, 2'b11, 16'h2222, 16'h3333);
        chk("rst_tie_owner", 32'(a_owner), 32'd0);
        chk("rst_tie_hex", 32'({a_h3, a_h2, a_h1, a_h0}), 32'({7'h24, 7'h24, 7'h24, 7'h24}));
        for (int i = 0; i < 600; i++) begin
            r0 = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            r1 = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 4095)) : 16'($urandom);
            step(logic'($urandom_range(0, 49) == 0), 2'($urandom), r0, r1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
